dma_host_programmer: RTL and testbench
======================================

Name: dma_host_programmer

Overview:
- Host-side initiator that programs and polls the DMA controller's register file over its slave I/O port (CS_N/IOR_N/IOW_N/A[3:0]/DB).
- Takes one channel-setup request and issues the complete register write sequence as timed I/O bus cycles.
- Takes status-read requests and returns the status byte.
- Sits between the host/testbench command source and the controller's programming port; used in integration benches and by the host-side system model.

Parameters:
- STROBE_CYCLES, 2, cycles IOR_N/IOW_N held low; must be >= 2 (elaboration check)
- RECOVERY_CYCLES, 1, idle cycles between consecutive bus cycles; must be >= 1
- DATAWIDTH, 8, data bus width
- ADDRESSWIDTH, 16, channel address/word-count width

Ports:
- CLK  in  1  clock
- RESET  in  1  reset
- cfg_valid  in  1  setup request valid
- cfg_ready  out  1  setup request accepted when cfg_valid & cfg_ready
- cfg_channel  in  2  target channel
- cfg_address  in  16  base address
- cfg_count  in  16  base word count
- cfg_mode  in  6  mode bits [7:2] of mode byte
- cfg_command  in  8  command register value
- stat_req  in  1  status read request; level, held until stat_valid
- stat_valid  out  1  one-cycle pulse, stat_data valid
- stat_data  out  8  captured status byte
- busy  out  1  sequence in progress
- HLDA  in  1  DMA owns bus; no new bus cycle may start while high
- CS_N, IOR_N, IOW_N  out  1 each  I/O strobes, active low
- A  out  4  register select {A3,A2,A1,A0}
- DB_OUT  out  8  write data
- DB_OE  out  1  DB_OUT drive enable
- DB_IN  in  8  read data

Interface: single clock CLK; RESET is synchronous, active-high.

Behaviour:
- Reset values: CS_N=IOR_N=IOW_N=1, A=0, DB_OUT=0, DB_OE=0, busy=0, stat_valid=0, stat_data=0. The FSM goes to IDLE.
- Reset asserted mid-sequence: aborts on the next edge; strobes return high immediately.
- cfg_ready is combinational: (state==IDLE) & !HLDA.
- Inputs are registered on acceptance; they may change afterwards.
- In IDLE with both cfg_valid and stat_req high, cfg wins. stat_req is served after the sequence completes if it is still high.
- Setup sequence, 7 writes in fixed order (A / data):
  1. 1100 / 0x00 (clear flip-flop)
  2. {0,ch,0} / addr[7:0]
  3. {0,ch,0} / addr[15:8]
  4. {0,ch,1} / count[7:0]
  5. {0,ch,1} / count[15:8]
  6. 1011 / {mode,ch}
  7. 1000 / command
- Status read: one read cycle at A=1000.
- Bus cycle FSM: IDLE -> SETUP(1) -> STROBE(STROBE_CYCLES) -> HOLD(1) -> RECOVER(RECOVERY_CYCLES) -> next step, or IDLE after the last step.
  - SETUP: CS_N=0; A valid; for writes, DB_OE=1 and DB_OUT valid.
  - STROBE: IOW_N=0 for writes, IOR_N=0 for reads.
  - HOLD: strobes high; CS_N, A and DB held.
  - RECOVER: CS_N=1, DB_OE=0, A held.
- IOR_N and IOW_N are never low simultaneously.
- Reads: DB_IN is sampled on the last STROBE cycle. stat_data updates and stat_valid pulses on the HOLD cycle.
- Write cycle length: 2+STROBE_CYCLES+RECOVERY_CYCLES = 5 at defaults. Full setup takes 35 cycles; the cfg handshake is followed by SETUP on the next cycle.
- HLDA:
  - Sampled only at RECOVER exit and in IDLE.
  - A bus cycle in progress always completes.
  - If HLDA=1 at RECOVER end, the FSM stays in RECOVER (all deasserted) until HLDA=0, then proceeds to the next step. The step index is preserved.
- busy=1 from the acceptance edge until return to IDLE; this includes a status read.
- A step counter (3 bits) indexes the sequence. Widths are fixed: no arithmetic beyond counter increments, and the counters saturate nowhere.

Test Plan:
- Reset then cfg ch=2, addr=0x1234, count=0x00FF, mode=0x15, cmd=0x40 -> 7 writes:
  - A=C/00, 4/34, 4/12, 5/FF, 5/00, B/0x56, 8/40
  - each with IOW_N low exactly 2 cycles; busy drops after 35 cycles; cfg_ready=1 after.
- stat_req with DB_IN=0x0F during STROBE -> one read at A=8; IOR_N low 2 cycles; DB_OE=0 throughout; stat_valid 1-cycle pulse; stat_data=0x0F.
- HLDA raised during the 3rd write's STROBE -> the write completes. The bus stays idle while HLDA=1 (hold 10 cycles). The 4th write starts 1 cycle after HLDA falls; data order is unchanged.
- cfg_valid and stat_req asserted the same cycle in IDLE -> setup runs first, then the status read; a single stat_valid pulse.
- RESET asserted during the 5th write's STROBE -> next cycle all strobes=1, DB_OE=0, busy=0. A new cfg then restarts from the clear-flip-flop write.
- HLDA=1 in IDLE with cfg_valid=1 -> cfg_ready=0, no bus activity. After HLDA drops, acceptance occurs and SETUP follows next cycle.

Source files
------------

// File: rtl/dma_host_programmer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dma_host_programmer: programs and polls a DMA controller through   |
// | its slave I/O port using timed CS_N/IOR_N/IOW_N bus cycles.        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module dma_host_programmer #(
  parameter int STROBE_CYCLES   = 2,
  parameter int RECOVERY_CYCLES = 1,
  parameter int DATAWIDTH       = 8,
  parameter int ADDRESSWIDTH    = 16
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [1:0]              cfg_channel,
  input  logic [ADDRESSWIDTH-1:0] cfg_address,
  input  logic [ADDRESSWIDTH-1:0] cfg_count,
  input  logic [5:0]              cfg_mode,
  input  logic [7:0]              cfg_command,
  input  logic                    stat_req,
  output logic                    stat_valid,
  output logic [7:0]              stat_data,
  output logic                    busy,
  input  logic                    HLDA,
  output logic                    CS_N,
  output logic                    IOR_N,
  output logic                    IOW_N,
  output logic [3:0]              A,
  output logic [DATAWIDTH-1:0]    DB_OUT,
  output logic                    DB_OE,
  input  logic [DATAWIDTH-1:0]    DB_IN
);

  generate
    if (STROBE_CYCLES < 2 || RECOVERY_CYCLES < 1) begin : g_param_check
      $error("dma_host_programmer: STROBE_CYCLES must be >= 2 and RECOVERY_CYCLES >= 1");
    end
  endgenerate

  localparam int SW = $clog2(STROBE_CYCLES + 1);
  localparam int RW = $clog2(RECOVERY_CYCLES + 1);
  localparam logic [SW-1:0] STB_LAST = SW'(STROBE_CYCLES - 1);
  localparam logic [RW-1:0] REC_LAST = RW'(RECOVERY_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_STROBE  = 3'd2,
    S_HOLD    = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              step_q, step_d;
  logic                    rd_q, rd_d;
  logic [SW-1:0]           stb_cnt_q, stb_cnt_d;
  logic [RW-1:0]           rec_cnt_q, rec_cnt_d;
  logic [1:0]              ch_q, ch_d;
  logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
  logic [ADDRESSWIDTH-1:0] count_q, count_d;
  logic [5:0]              mode_q, mode_d;
  logic [7:0]              cmd_q, cmd_d;
  logic [3:0]              a_q, a_d;
  logic [DATAWIDTH-1:0]    db_q, db_d;
  logic [7:0]              stat_data_q, stat_data_d;

  // Register select and data byte for the step that follows step_q.
  logic [2:0] step_inc;
  logic [3:0] inc_a;
  logic [7:0] inc_byte;

  always_comb begin
    step_inc = step_q + 3'd1;
    inc_a    = 4'b1000;
    inc_byte = cmd_q;
    case (step_inc)
      3'd1: begin inc_a = {1'b0, ch_q, 1'b0}; inc_byte = addr_q[7:0];   end
      3'd2: begin inc_a = {1'b0, ch_q, 1'b0}; inc_byte = addr_q[15:8];  end
      3'd3: begin inc_a = {1'b0, ch_q, 1'b1}; inc_byte = count_q[7:0];  end
      3'd4: begin inc_a = {1'b0, ch_q, 1'b1}; inc_byte = count_q[15:8]; end
      3'd5: begin inc_a = 4'b1011;            inc_byte = {mode_q, ch_q}; end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    rd_d        = rd_q;
    stb_cnt_d   = stb_cnt_q;
    rec_cnt_d   = rec_cnt_q;
    ch_d        = ch_q;
    addr_d      = addr_q;
    count_d     = count_q;
    mode_d      = mode_q;
    cmd_d       = cmd_q;
    a_d         = a_q;
    db_d        = db_q;
    stat_data_d = stat_data_q;
    cfg_ready   = (state_q == S_IDLE) && !HLDA;

    case (state_q)
      S_IDLE: begin
        if (cfg_ready && cfg_valid) begin
          ch_d    = cfg_channel;
          addr_d  = cfg_address;
          count_d = cfg_count;
          mode_d  = cfg_mode;
          cmd_d   = cfg_command;
          step_d  = 3'd0;
          rd_d    = 1'b0;
          a_d     = 4'b1100;
          db_d    = '0;
          state_d = S_SETUP;
        end else if (cfg_ready && stat_req) begin
          step_d  = 3'd0;
          rd_d    = 1'b1;
          a_d     = 4'b1000;
          db_d    = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        stb_cnt_d = '0;
        state_d   = S_STROBE;
      end
      S_STROBE: begin
        if (stb_cnt_q == STB_LAST) begin
          if (rd_q) stat_data_d = DB_IN[7:0];
          state_d = S_HOLD;
        end else begin
          stb_cnt_d = stb_cnt_q + SW'(1);
        end
      end
      S_HOLD: begin
        rec_cnt_d = '0;
        state_d   = S_RECOVER;
      end
      S_RECOVER: begin
        // HLDA only gates the start of the next bus cycle; the count stays parked.
        if (rec_cnt_q != REC_LAST) begin
          rec_cnt_d = rec_cnt_q + RW'(1);
        end else if (!HLDA) begin
          if (rd_q || step_q == 3'd6) begin
            state_d = S_IDLE;
          end else begin
            step_d  = step_inc;
            a_d     = inc_a;
            db_d    = DATAWIDTH'(inc_byte);
            state_d = S_SETUP;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      rd_q        <= 1'b0;
      stb_cnt_q   <= '0;
      rec_cnt_q   <= '0;
      ch_q        <= '0;
      addr_q      <= '0;
      count_q     <= '0;
      mode_q      <= '0;
      cmd_q       <= '0;
      a_q         <= '0;
      db_q        <= '0;
      stat_data_q <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      rd_q        <= rd_d;
      stb_cnt_q   <= stb_cnt_d;
      rec_cnt_q   <= rec_cnt_d;
      ch_q        <= ch_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      mode_q      <= mode_d;
      cmd_q       <= cmd_d;
      a_q         <= a_d;
      db_q        <= db_d;
      stat_data_q <= stat_data_d;
    end
  end

  logic cs_active;
  assign cs_active  = (state_q == S_SETUP) || (state_q == S_STROBE) || (state_q == S_HOLD);
  assign busy       = (state_q != S_IDLE);
  assign CS_N       = !cs_active;
  assign IOW_N      = !((state_q == S_STROBE) && !rd_q);
  assign IOR_N      = !((state_q == S_STROBE) && rd_q);
  assign DB_OE      = cs_active && !rd_q;
  assign stat_valid = (state_q == S_HOLD) && rd_q;
  assign A          = a_q;
  assign DB_OUT     = db_q;
  assign stat_data  = stat_data_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_host_programmer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_dma_host_programmer: bus-transaction reference model and        |
// | directed plus random stimulus for dma_host_programmer.             |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_dma_host_programmer;
  localparam int S = 2;
  localparam int R = 1;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        cfg_valid = 1'b0;
  logic [1:0]  cfg_channel = '0;
  logic [15:0] cfg_address = '0;
  logic [15:0] cfg_count = '0;
  logic [5:0]  cfg_mode = '0;
  logic [7:0]  cfg_command = '0;
  logic        stat_req = 1'b0;
  logic        HLDA = 1'b0;
  logic [7:0]  DB_IN = '0;
  logic        cfg_ready, stat_valid, busy, CS_N, IOR_N, IOW_N, DB_OE;
  logic [7:0]  stat_data, DB_OUT;
  logic [3:0]  A;

  dma_host_programmer #(.STROBE_CYCLES(S), .RECOVERY_CYCLES(R), .DATAWIDTH(8), .ADDRESSWIDTH(16)) dut (
    .CLK(CLK), .RESET(RESET), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_channel(cfg_channel), .cfg_address(cfg_address), .cfg_count(cfg_count),
    .cfg_mode(cfg_mode), .cfg_command(cfg_command), .stat_req(stat_req),
    .stat_valid(stat_valid), .stat_data(stat_data), .busy(busy), .HLDA(HLDA),
    .CS_N(CS_N), .IOR_N(IOR_N), .IOW_N(IOW_N), .A(A), .DB_OUT(DB_OUT),
    .DB_OE(DB_OE), .DB_IN(DB_IN)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at time %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending bus operations and the cycle offset t
  // inside the current one (0 setup, 1..S strobe, S+1 hold, then recovery).
  typedef struct packed { logic rd; logic [3:0] a; logic [7:0] d; } op_t;
  op_t        ops[$];
  op_t        cur = '0;
  bit         m_active = 0;
  int         t = 0;
  logic [7:0] m_stat = '0;

  function automatic op_t mk(input logic rd, input logic [3:0] a, input logic [7:0] d);
    op_t o;
    o.rd = rd; o.a = a; o.d = d;
    return o;
  endfunction

  task automatic model_step();
    if (RESET) begin
      m_active = 0; ops.delete(); t = 0; m_stat = '0;
    end else if (!m_active) begin
      if (!HLDA && cfg_valid) begin
        ops.delete();
        ops.push_back(mk(1'b0, 4'hC, 8'h00));
        ops.push_back(mk(1'b0, {1'b0, cfg_channel, 1'b0}, cfg_address[7:0]));
        ops.push_back(mk(1'b0, {1'b0, cfg_channel, 1'b0}, cfg_address[15:8]));
        ops.push_back(mk(1'b0, {1'b0, cfg_channel, 1'b1}, cfg_count[7:0]));
        ops.push_back(mk(1'b0, {1'b0, cfg_channel, 1'b1}, cfg_count[15:8]));
        ops.push_back(mk(1'b0, 4'hB, {cfg_mode, cfg_channel}));
        ops.push_back(mk(1'b0, 4'h8, cfg_command));
      end else if (!HLDA && stat_req) begin
        ops.push_back(mk(1'b1, 4'h8, 8'h00));
      end
      if (ops.size() != 0) begin cur = ops.pop_front(); t = 0; m_active = 1; end
    end else begin
      if (t == S && cur.rd) m_stat = DB_IN;
      if (t < S + 1 + R) t++;
      else if (!HLDA) begin
        if (ops.size() == 0) m_active = 0;
        else begin cur = ops.pop_front(); t = 0; end
      end
    end
  endtask

  // Observation logs used by the directed literal checks.
  logic [3:0] wr_a[$];
  logic [7:0] wr_d[$];
  int         wr_len[$];
  int         rd_len[$];
  logic [7:0] rd_data[$];
  int sv_cnt = 0, busy_cnt = 0, oe_cnt = 0, iow_run = 0, ior_run = 0;
  logic prev_iow = 1'b1;

  task automatic clr_logs();
    wr_a.delete(); wr_d.delete(); wr_len.delete(); rd_len.delete(); rd_data.delete();
    sv_cnt = 0; busy_cnt = 0; oe_cnt = 0;
  endtask

  initial begin
    forever begin
      @(posedge CLK);
      model_step();
      #2;
      chk("busy", 32'(busy), 32'(m_active));
      chk("cs_n", 32'(CS_N), 32'(!(m_active && t <= S + 1)));
      chk("iow_n", 32'(IOW_N), 32'(!(m_active && !cur.rd && t >= 1 && t <= S)));
      chk("ior_n", 32'(IOR_N), 32'(!(m_active && cur.rd && t >= 1 && t <= S)));
      chk("db_oe", 32'(DB_OE), 32'(m_active && !cur.rd && t <= S + 1));
      chk("stat_valid", 32'(stat_valid), 32'(m_active && cur.rd && t == S + 1));
      chk("stat_data", 32'(stat_data), 32'(m_stat));
      chk("cfg_ready", 32'(cfg_ready), 32'(!m_active && !HLDA));
      if (m_active) chk("addr", 32'(A), 32'(cur.a));
      if (m_active && !cur.rd && t <= S + 1) chk("db_out", 32'(DB_OUT), 32'(cur.d));
      if (!IOW_N && prev_iow) begin wr_a.push_back(A); wr_d.push_back(DB_OUT); end
      if (!IOW_N) iow_run++; else if (iow_run != 0) begin wr_len.push_back(iow_run); iow_run = 0; end
      if (!IOR_N) ior_run++; else if (ior_run != 0) begin rd_len.push_back(ior_run); ior_run = 0; end
      if (stat_valid) begin sv_cnt++; rd_data.push_back(stat_data); end
      if (busy) busy_cnt++;
      if (DB_OE) oe_cnt++;
      prev_iow = IOW_N;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_cfg(input logic [1:0] ch, input logic [15:0] ad, input logic [15:0] cn,
                          input logic [5:0] md, input logic [7:0] cm);
    bit ok;
    ok = 0;
    cfg_channel = ch; cfg_address = ad; cfg_count = cn; cfg_mode = md; cfg_command = cm;
    cfg_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      #1 ok = cfg_ready;
      @(negedge CLK);
    end
    cfg_valid = 1'b0;
    cfg_address = 16'($urandom); cfg_count = 16'($urandom); cfg_command = 8'($urandom);
    chk("cfg_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input int lim);
    int i;
    i = 0;
    while (busy && i < lim) begin @(negedge CLK); i++; end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_wr(input int n, input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge CLK);
      ok = (wr_a.size() == n) && !IOW_N;
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic wait_stat(input int lim);
    bit seen;
    seen = 0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge CLK);
      if (stat_valid) seen = 1;
    end
    stat_req = 1'b0;
    chk("stat_seen", 32'(seen), 32'd1);
  endtask

  task automatic chk_writes(input string nm, input logic [3:0] ea[7], input logic [7:0] ed[7]);
    chk({nm, "_count"}, 32'(wr_a.size()), 32'd7);
    for (int i = 0; i < 7; i++) begin
      if (i < wr_a.size()) begin
        chk({nm, "_a"}, 32'(wr_a[i]), 32'(ea[i]));
        chk({nm, "_d"}, 32'(wr_d[i]), 32'(ed[i]));
      end
      if (i < wr_len.size()) chk({nm, "_iow_len"}, 32'(wr_len[i]), 32'd2);
    end
  endtask

  initial begin
    logic [3:0] ea[7];
    logic [7:0] ed[7];
    bit last_ready;

    tick(3);
    chk("rst_cs_n", 32'(CS_N), 32'd1);
    chk("rst_ior_n", 32'(IOR_N), 32'd1);
    chk("rst_iow_n", 32'(IOW_N), 32'd1);
    chk("rst_a", 32'(A), 32'd0);
    chk("rst_db_out", 32'(DB_OUT), 32'd0);
    chk("rst_db_oe", 32'(DB_OE), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stat", 32'({stat_valid, stat_data}), 32'd0);
    RESET = 1'b0;
    tick(2);

    // Basic channel setup.
    clr_logs();
    send_cfg(2'd2, 16'h1234, 16'h00FF, 6'h15, 8'h40);
    wait_idle(100);
    ea = '{4'hC, 4'h4, 4'h4, 4'h5, 4'h5, 4'hB, 4'h8};
    ed = '{8'h00, 8'h34, 8'h12, 8'hFF, 8'h00, 8'h56, 8'h40};
    chk_writes("setup1", ea, ed);
    chk("setup1_busy_cycles", 32'(busy_cnt), 32'd35);
    chk("setup1_ready_after", 32'(cfg_ready), 32'd1);

    // Status read.
    tick(2);
    clr_logs();
    DB_IN = 8'h0F;
    stat_req = 1'b1;
    wait_stat(50);
    wait_idle(50);
    chk("stat_pulses", 32'(sv_cnt), 32'd1);
    chk("stat_value", 32'(stat_data), 32'h0F);
    chk("stat_no_writes", 32'(wr_a.size()), 32'd0);
    chk("stat_oe_cycles", 32'(oe_cnt), 32'd0);
    chk("stat_ior_len", 32'((rd_len.size() == 1) ? rd_len[0] : -1), 32'd2);

    // HLDA during the third write.
    tick(2);
    clr_logs();
    send_cfg(2'd1, 16'hABCD, 16'h0102, 6'h3F, 8'hA5);
    wait_wr(3, "reach_wr3");
    HLDA = 1'b1;
    tick(10);
    chk("hlda_bus_idle", 32'(CS_N), 32'd1);
    chk("hlda_wr_held", 32'(wr_a.size()), 32'd3);
    HLDA = 1'b0;
    tick(1);
    chk("hlda_resume_cs", 32'(CS_N), 32'd0);
    chk("hlda_resume_a", 32'(A), 32'h3);
    chk("hlda_resume_db", 32'(DB_OUT), 32'h02);
    wait_idle(100);
    ea = '{4'hC, 4'h2, 4'h2, 4'h3, 4'h3, 4'hB, 4'h8};
    ed = '{8'h00, 8'hCD, 8'hAB, 8'h02, 8'h01, 8'hFD, 8'hA5};
    chk_writes("hlda", ea, ed);

    // cfg and status requested together.
    tick(2);
    clr_logs();
    DB_IN = 8'h3C;
    stat_req = 1'b1;
    send_cfg(2'd0, 16'h0F0E, 16'h1000, 6'h2A, 8'h04);
    wait_stat(100);
    chk("both_writes_first", 32'(wr_a.size()), 32'd7);
    wait_idle(50);
    tick(8);
    chk("both_pulses", 32'(sv_cnt), 32'd1);
    chk("both_stat", 32'(stat_data), 32'h3C);
    ea = '{4'hC, 4'h0, 4'h0, 4'h1, 4'h1, 4'hB, 4'h8};
    ed = '{8'h00, 8'h0E, 8'h0F, 8'h00, 8'h10, 8'hA8, 8'h04};
    chk_writes("both", ea, ed);

    // Reset during the fifth write, then restart.
    clr_logs();
    send_cfg(2'd3, 16'h5A5A, 16'h0007, 6'h01, 8'h81);
    wait_wr(5, "reach_wr5");
    RESET = 1'b1;
    tick(1);
    chk("midrst_strobes", 32'({CS_N, IOR_N, IOW_N}), 32'h7);
    chk("midrst_db_oe", 32'(DB_OE), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    RESET = 1'b0;
    tick(1);
    clr_logs();
    send_cfg(2'd3, 16'h5A5A, 16'h0007, 6'h01, 8'h81);
    wait_idle(100);
    ea = '{4'hC, 4'h6, 4'h6, 4'h7, 4'h7, 4'hB, 4'h8};
    ed = '{8'h00, 8'h5A, 8'h5A, 8'h07, 8'h00, 8'h07, 8'h81};
    chk_writes("restart", ea, ed);

    // HLDA in IDLE blocks acceptance.
    tick(2);
    HLDA = 1'b1;
    cfg_channel = 2'd2; cfg_address = 16'h8001; cfg_count = 16'h0010;
    cfg_mode = 6'h00; cfg_command = 8'h00;
    cfg_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("idle_hlda_ready", 32'(cfg_ready), 32'd0);
      chk("idle_hlda_busy", 32'(busy), 32'd0);
      chk("idle_hlda_cs", 32'(CS_N), 32'd1);
      @(negedge CLK);
    end
    HLDA = 1'b0;
    #1;
    chk("idle_hlda_ready_drop", 32'(cfg_ready), 32'd1);
    @(negedge CLK);
    cfg_valid = 1'b0;
    chk("idle_hlda_setup_busy", 32'(busy), 32'd1);
    chk("idle_hlda_setup_cs", 32'(CS_N), 32'd0);
    chk("idle_hlda_setup_a", 32'(A), 32'hC);
    wait_idle(100);

    // Randomized traffic with HLDA stalls and occasional resets.
    last_ready = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge CLK);
      if (RESET) RESET = 1'b0;
      else if ($urandom_range(0, 299) == 0) RESET = 1'b1;
      if (cfg_valid && last_ready) begin
        cfg_valid = 1'b0;
        cfg_address = 16'($urandom); cfg_count = 16'($urandom);
        cfg_mode = 6'($urandom); cfg_command = 8'($urandom); cfg_channel = 2'($urandom);
      end
      if (stat_req && stat_valid) stat_req = 1'b0;
      if (!cfg_valid && $urandom_range(0, 9) == 0) begin
        cfg_channel = 2'($urandom); cfg_address = 16'($urandom); cfg_count = 16'($urandom);
        cfg_mode = 6'($urandom); cfg_command = 8'($urandom);
        cfg_valid = 1'b1;
      end
      if (!stat_req && $urandom_range(0, 11) == 0) stat_req = 1'b1;
      if ($urandom_range(0, 9) == 0) HLDA = !HLDA;
      DB_IN = 8'($urandom);
      #1 last_ready = cfg_ready;
    end
    @(negedge CLK);
    RESET = 1'b0; HLDA = 1'b0; cfg_valid = 1'b0; stat_req = 1'b0;
    wait_idle(200);
    tick(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
